mem_access_ctrl: RTL and testbench
==================================

MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 Parameter READ_LAT, default 2, memory read latency in cycles; legal 1..7.
REQ-002 Clock  input  1  single processor clock; all state updates on rising edge.
REQ-003 Reset  input  1  synchronous, active-high reset.
REQ-004 F_Req  input  1  fetch-port read request; held high until F_Ack.
REQ-005 F_Addr  input  16  fetch address.
REQ-006 F_Ack  output  1  one-cycle fetch completion pulse.
REQ-007 F_Data  output  16  fetch read data.
REQ-008 D_Req  input  1  data-port request; held high until D_Ack.
REQ-009 D_We  input  1  data-port write (1) or read (0).
REQ-010 D_Addr  input  16  data-port address.
REQ-011 D_Wdata  input  16  data-port write data.
REQ-012 D_Ack  output  1  one-cycle data completion pulse.
REQ-013 D_Data  output  16  data-port read data.
REQ-014 Mem_Addr  output  16  address to the shared memory.
REQ-015 Mem_Dout  output  16  write data to memory.
REQ-016 Mem_We  output  1  memory write enable (W_D).
REQ-017 Mem_Din  input  16  memory read data; valid READ_LAT cycles after Mem_Addr is presented.
REQ-018 Busy  output  1  high whenever state is not IDLE.
REQ-019 Gnt_D  output  1  current or last owner: 1 = data port, 0 = fetch port.

Function
REQ-020 FSM states: IDLE, ACCESS, RESP; encoding is free.
REQ-021 IDLE with no request: remain in IDLE; Mem_We=0; both Acks=0.
REQ-022 IDLE with a request: on the same edge, grant one port; latch its address, write flag and write data into Mem_Addr, Mem_Dout and internal registers; go to ACCESS.
REQ-023 Only one request pending: grant that port.
REQ-024 Both requests pending: grant the port not granted in the previous transaction (round-robin); a last-grant pointer of fetch makes data win.
REQ-025 ACCESS, write: exactly one cycle, with Mem_We=1; then go to RESP.
REQ-026 ACCESS, read: exactly READ_LAT cycles, counted by a 3-bit counter, with Mem_We=0.
REQ-027 ACCESS, read, last cycle: capture Mem_Din into the granted port's data register on the exiting edge; go to RESP.
REQ-028 RESP: exactly one cycle; assert the granted port's Ack only.
REQ-029 Data registers: F_Data/D_Data are valid during Ack and hold their value until that port's next read capture; writes do not alter D_Data.
REQ-030 RESP exit: always go to IDLE; the earliest next grant is the IDLE cycle after RESP.
REQ-031 Requester rule: a port must drop Req, or present a new request, by the edge ending its Ack cycle.
REQ-032 Read latency: Req sampled in IDLE at cycle N gives Ack in cycle N+1+READ_LAT.
REQ-033 Write latency: Req sampled in IDLE at cycle N gives Ack in cycle N+2.
REQ-034 Req dropped after grant: the transaction still completes and the Ack is still issued.
REQ-035 Request changes mid-transaction: addresses, data and D_We changes after the grant are ignored; the latched values are used.
REQ-036 Non-granted port: its Req stays pending without loss; it is served in the next IDLE.
REQ-037 Mem_Addr and Mem_Dout hold their last latched values in IDLE and RESP.
REQ-038 At most one Ack is high in any cycle; Mem_We is never high outside ACCESS.

Reset
REQ-039 Reset takes priority in any state, including mid-ACCESS.
REQ-040 Reset values: state=IDLE, Mem_We=0, F_Ack=D_Ack=0, Busy=0, Mem_Addr=0, Mem_Dout=0, F_Data=D_Data=0, counter=0, Gnt_D=0, last-grant pointer=fetch.
REQ-041 Reset aborts any in-flight transaction; no Ack is issued for it.
REQ-042 Requests still high after Reset deasserts are arbitrated fresh in IDLE.

Verification
REQ-043 Fetch read, READ_LAT=2: F_Req, F_Addr=0x0004 sampled in cycle 0; Mem_Din=0xA5A5 -> Mem_Addr=0x0004 in cycles 1-2; F_Ack and F_Data=0xA5A5 in cycle 3 only.
REQ-044 Data write: D_Req, D_We=1, D_Addr=0x0010, D_Wdata=0x1234 in cycle 0 -> Mem_We=1 in cycle 1 only; D_Ack in cycle 2; D_Data unchanged.
REQ-045 Contention after reset: F_Req and D_Req both held -> data served first; fetch Ack follows; then ports alternate; never two Acks in one cycle.
REQ-046 Reset in cycle 2 of a write-free read -> no Ack issued; Busy=0 and all outputs at reset values in the next cycle.
REQ-047 READ_LAT=1 and READ_LAT=7 -> fetch Ack in cycles 2 and 8 after the grant; Busy high exactly from the grant edge through RESP.

Source files
------------

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl
//   Arbitrates a fetch port and a data port onto a single shared memory.
//   One transaction at a time: IDLE -> ACCESS -> RESP -> IDLE.
//   Both ports are served round-robin when they contend.
//
// Ports
//   Clock, Reset        rising-edge clock, synchronous active-high reset
//   F_Req/F_Addr        fetch read request and address
//   F_Ack/F_Data        one-cycle fetch completion pulse and read data
//   D_Req/D_We/D_Addr/D_Wdata  data-port request (write when D_We=1)
//   D_Ack/D_Data        one-cycle data completion pulse and read data
//   Mem_Addr/Mem_Dout/Mem_We   shared memory address, write data, write enable
//   Mem_Din             memory read data, valid READ_LAT cycles after address
//   Busy                high whenever a transaction is in progress
//   Gnt_D               owner of the current or last transaction (1 = data)
module mem_access_ctrl #(
  parameter int unsigned READ_LAT = 2
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        F_Req,
  input  logic [15:0] F_Addr,
  output logic        F_Ack,
  output logic [15:0] F_Data,
  input  logic        D_Req,
  input  logic        D_We,
  input  logic [15:0] D_Addr,
  input  logic [15:0] D_Wdata,
  output logic        D_Ack,
  output logic [15:0] D_Data,
  output logic [15:0] Mem_Addr,
  output logic [15:0] Mem_Dout,
  output logic        Mem_We,
  input  logic [15:0] Mem_Din,
  output logic        Busy,
  output logic        Gnt_D
);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_t;

  localparam logic [2:0] LAST_CNT = 3'(READ_LAT - 1);

  state_t     state;
  logic [2:0] cnt;
  logic       we_q;
  logic       pick_d;

  // Gnt_D doubles as the last-grant pointer: on contention the port that
  // did not own the previous transaction wins.
  always_comb begin
    pick_d = D_Req && (!F_Req || !Gnt_D);
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state    <= IDLE;
      cnt      <= '0;
      we_q     <= 1'b0;
      F_Ack    <= 1'b0;
      D_Ack    <= 1'b0;
      F_Data   <= '0;
      D_Data   <= '0;
      Mem_Addr <= '0;
      Mem_Dout <= '0;
      Mem_We   <= 1'b0;
      Busy     <= 1'b0;
      Gnt_D    <= 1'b0;
    end else begin
      F_Ack <= 1'b0;
      D_Ack <= 1'b0;
      unique case (state)
        IDLE: begin
          if (F_Req || D_Req) begin
            Gnt_D    <= pick_d;
            we_q     <= pick_d && D_We;
            Mem_We   <= pick_d && D_We;
            Mem_Addr <= pick_d ? D_Addr : F_Addr;
            if (pick_d) begin
              Mem_Dout <= D_Wdata;
            end
            cnt   <= '0;
            Busy  <= 1'b1;
            state <= ACCESS;
          end
        end

        ACCESS: begin
          if (we_q) begin
            Mem_We <= 1'b0;
            D_Ack  <= 1'b1;
            state  <= RESP;
          end else if (cnt == LAST_CNT) begin
            // Capture on the exiting edge so data is valid during the Ack.
            if (Gnt_D) begin
              D_Data <= Mem_Din;
              D_Ack  <= 1'b1;
            end else begin
              F_Data <= Mem_Din;
              F_Ack  <= 1'b1;
            end
            state <= RESP;
          end else begin
            cnt <= cnt + 3'd1;
          end
        end

        RESP: begin
          Busy  <= 1'b0;
          state <= IDLE;
        end

        default: begin
          Busy   <= 1'b0;
          Mem_We <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl
//   Directed bench for mem_access_ctrl. The main instance (READ_LAT=2) is
//   compared every cycle against a transaction-level model that tracks how
//   many cycles remain until the Ack. Two extra instances (READ_LAT=1 and 7)
//   are checked against literal Ack/Busy timing.
module tb_mem_access_ctrl;
  localparam int unsigned RL = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        f_req, f_ack, d_req, d_we, d_ack, mem_we, busy, gnt_d;
  logic [15:0] f_addr, f_data, d_addr, d_wdata, d_data;
  logic [15:0] mem_addr, mem_dout, mem_din;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;
  bit ack_log[$];

  function automatic logic [15:0] mem_val(input logic [15:0] a);
    if (a == 16'h0004) return 16'hA5A5;
    return (a ^ 16'h5A3C) + 16'h0101;
  endfunction

  assign mem_din = mem_val(mem_addr);

  mem_access_ctrl #(.READ_LAT(RL)) dut (
    .Clock(clk), .Reset(rst),
    .F_Req(f_req), .F_Addr(f_addr), .F_Ack(f_ack), .F_Data(f_data),
    .D_Req(d_req), .D_We(d_we), .D_Addr(d_addr), .D_Wdata(d_wdata),
    .D_Ack(d_ack), .D_Data(d_data),
    .Mem_Addr(mem_addr), .Mem_Dout(mem_dout), .Mem_We(mem_we), .Mem_Din(mem_din),
    .Busy(busy), .Gnt_D(gnt_d)
  );

  // Latency-variant instances, fetch port only.
  logic        zero1 = 1'b0;
  logic [15:0] zero16 = 16'h0000;
  logic [15:0] aux_addr = 16'h0004;
  logic        a_req, a_ack, a_dack, a_we, a_busy, a_gnt;
  logic        b_req, b_ack, b_dack, b_we, b_busy, b_gnt;
  logic [15:0] a_fdata, a_ddata, a_maddr, a_mdout, a_mdin;
  logic [15:0] b_fdata, b_ddata, b_maddr, b_mdout, b_mdin;
  assign a_mdin = mem_val(a_maddr);
  assign b_mdin = mem_val(b_maddr);

  mem_access_ctrl #(.READ_LAT(1)) dut_l1 (
    .Clock(clk), .Reset(rst),
    .F_Req(a_req), .F_Addr(aux_addr), .F_Ack(a_ack), .F_Data(a_fdata),
    .D_Req(zero1), .D_We(zero1), .D_Addr(zero16), .D_Wdata(zero16),
    .D_Ack(a_dack), .D_Data(a_ddata),
    .Mem_Addr(a_maddr), .Mem_Dout(a_mdout), .Mem_We(a_we), .Mem_Din(a_mdin),
    .Busy(a_busy), .Gnt_D(a_gnt)
  );

  mem_access_ctrl #(.READ_LAT(7)) dut_l7 (
    .Clock(clk), .Reset(rst),
    .F_Req(b_req), .F_Addr(aux_addr), .F_Ack(b_ack), .F_Data(b_fdata),
    .D_Req(zero1), .D_We(zero1), .D_Addr(zero16), .D_Wdata(zero16),
    .D_Ack(b_dack), .D_Data(b_ddata),
    .Mem_Addr(b_maddr), .Mem_Dout(b_mdout), .Mem_We(b_we), .Mem_Din(b_mdin),
    .Busy(b_busy), .Gnt_D(b_gnt)
  );

  // Model: m_left counts cycles still to go in the transaction, ending with
  // the Ack cycle at m_left==1; zero means idle.
  int          m_left  = 0;
  logic        m_owner = 1'b0;
  logic        m_we    = 1'b0;
  logic [15:0] m_addr  = '0;
  logic [15:0] m_dout  = '0;
  logic [15:0] m_fdata = '0;
  logic [15:0] m_ddata = '0;

  function automatic logic model_pick(input logic fr, input logic dr, input logic last_d);
    if (fr && dr) return !last_d;
    return dr;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_left  <= 0;
      m_owner <= 1'b0;
      m_we    <= 1'b0;
      m_addr  <= '0;
      m_dout  <= '0;
      m_fdata <= '0;
      m_ddata <= '0;
    end else if (m_left != 0) begin
      m_left <= m_left - 1;
      if (m_left == 2 && !m_we) begin
        if (m_owner) m_ddata <= mem_val(m_addr);
        else         m_fdata <= mem_val(m_addr);
      end
    end else if (f_req || d_req) begin
      m_owner <= model_pick(f_req, d_req, m_owner);
      m_we    <= model_pick(f_req, d_req, m_owner) && d_we;
      m_addr  <= model_pick(f_req, d_req, m_owner) ? d_addr : f_addr;
      if (model_pick(f_req, d_req, m_owner)) m_dout <= d_wdata;
      m_left  <= (model_pick(f_req, d_req, m_owner) && d_we) ? 2 : int'(RL) + 1;
    end
  end

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy",     16'(busy),   16'(m_left != 0));
      chk("f_ack",    16'(f_ack),  16'(m_left == 1 && !m_owner));
      chk("d_ack",    16'(d_ack),  16'(m_left == 1 && m_owner));
      chk("mem_we",   16'(mem_we), 16'(m_left == 2 && m_we));
      chk("gnt_d",    16'(gnt_d),  16'(m_owner));
      chk("mem_addr", mem_addr, m_addr);
      chk("mem_dout", mem_dout, m_dout);
      chk("f_data",   f_data,   m_fdata);
      chk("d_data",   d_data,   m_ddata);
      chk("one_ack",  16'(f_ack & d_ack), 16'h0000);
      if (d_ack) ack_log.push_back(1'b1);
      if (f_ack) ack_log.push_back(1'b0);
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic wait_ack(input bit port_d, input string name);
    int n;
    n = 0;
    tick();
    while (!(port_d ? d_ack : f_ack) && n < 20) begin
      tick();
      n++;
    end
    chk(name, 16'(port_d ? d_ack : f_ack), 16'h0001);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; f_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    f_addr = '0; d_addr = '0; d_wdata = '0; a_req = 1'b0; b_req = 1'b0;
    tick(); tick();
    chk_en = 1'b1;
    chk("rst_busy", 16'(busy), 16'h0000);
    chk("rst_addr", mem_addr, 16'h0000);
    chk("rst_gnt",  16'(gnt_d), 16'h0000);
    rst = 1'b0;
    tick();

    // Fetch read at address 4; address change after grant is ignored.
    f_req = 1'b1; f_addr = 16'h0004;
    tick();
    chk("fr_c1_addr", mem_addr, 16'h0004);
    chk("fr_c1_busy", 16'(busy), 16'h0001);
    f_addr = 16'h0FFF;
    tick();
    chk("fr_c2_addr", mem_addr, 16'h0004);
    chk("fr_c2_ack",  16'(f_ack), 16'h0000);
    tick();
    chk("fr_c3_ack",  16'(f_ack), 16'h0001);
    chk("fr_c3_data", f_data, 16'hA5A5);
    f_req = 1'b0;
    tick();
    chk("fr_c4_ack",  16'(f_ack), 16'h0000);

    // Data write; D_We/D_Wdata changes after grant are ignored.
    d_req = 1'b1; d_we = 1'b1; d_addr = 16'h0010; d_wdata = 16'h1234;
    tick();
    chk("wr_c1_we",   16'(mem_we), 16'h0001);
    chk("wr_c1_dout", mem_dout, 16'h1234);
    d_we = 1'b0; d_wdata = 16'hFFFF;
    tick();
    chk("wr_c2_we",   16'(mem_we), 16'h0000);
    chk("wr_c2_ack",  16'(d_ack), 16'h0001);
    chk("wr_c2_data", d_data, 16'h0000);
    d_req = 1'b0;
    tick();

    // Data read, then a write that must leave D_Data alone.
    d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0020;
    wait_ack(1'b1, "dr_ack");
    chk("dr_data", d_data, 16'h5B1D);
    d_req = 1'b0;
    tick();
    d_req = 1'b1; d_we = 1'b1; d_addr = 16'h0030; d_wdata = 16'hBEEF;
    wait_ack(1'b1, "wr2_ack");
    chk("wr2_data_hold", d_data, 16'h5B1D);
    d_req = 1'b0;
    tick();

    // Contention from reset: data first, then strict alternation.
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    ack_log.delete();
    f_req = 1'b1; d_req = 1'b1;
    for (int i = 0; i < 40; i++) begin
      f_addr  = 16'h0100 + 16'(i);
      d_addr  = 16'h0200 + 16'(i);
      d_we    = (i % 3) == 1;
      d_wdata = 16'(i * 7);
      tick();
    end
    f_req = 1'b0; d_req = 1'b0;
    tick(); tick(); tick(); tick();
    chk("cont_count", 16'(ack_log.size() >= 4), 16'h0001);
    if (ack_log.size() >= 2) begin
      chk("cont_first_d", 16'(ack_log[0]), 16'h0001);
      chk("cont_second_f", 16'(ack_log[1]), 16'h0000);
      for (int i = 1; i < ack_log.size(); i++)
        chk("cont_alternate", 16'(ack_log[i] != ack_log[i-1]), 16'h0001);
    end

    // Reset in cycle 2 of a read aborts it.
    f_req = 1'b1; f_addr = 16'h0040;
    tick();
    tick();
    rst = 1'b1;
    tick();
    chk("abort_busy", 16'(busy), 16'h0000);
    chk("abort_ack",  16'(f_ack), 16'h0000);
    chk("abort_addr", mem_addr, 16'h0000);
    chk("abort_fdat", f_data, 16'h0000);
    f_req = 1'b0; rst = 1'b0;
    tick(); tick(); tick();

    // Latency-variant instances: Ack at 2 and 8 cycles after the grant.
    a_req = 1'b1; b_req = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      tick();
      chk("l1_ack",  16'(a_ack),  16'(k == 2));
      chk("l1_busy", 16'(a_busy), 16'(k <= 2));
      chk("l7_ack",  16'(b_ack),  16'(k == 8));
      chk("l7_busy", 16'(b_busy), 16'(k <= 8));
      if (a_ack) begin
        chk("l1_data", a_fdata, 16'hA5A5);
        a_req = 1'b0;
      end
      if (b_ack) begin
        chk("l7_data", b_fdata, 16'hA5A5);
        b_req = 1'b0;
      end
    end
    chk("l1_we", 16'(a_we | a_dack | a_gnt), 16'h0000);
    chk("l7_we", 16'(b_we | b_dack | b_gnt), 16'h0000);

    tick(); tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
